// File: rtl/sum_window_ctrl.sv
// Windowed accumulation sequencer for the lock-in sample stream.
// Waits a settle period, sums exactly L valid samples, and publishes the
// sum through a valid/ready output register. Supports single-shot and
// back-to-back (continuous) windows, abort via stop, and a sticky overrun
// flag when an untaken result is overwritten.
//
// Output handshake: sum_valid is high while sum_out holds a result the
// consumer has not taken; a transfer happens on any cycle where
// sum_valid && sum_ready are both high. sum_out is stable while sum_valid
// is high, unless a newer window completes (then sum_out is replaced). If
// that happens without a transfer in the same cycle, overrun is set.
module sum_window_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          continuous,
  input  logic [CNT_W-1:0]              win_len,
  input  logic [CNT_W-1:0]              settle_len,
  input  logic signed [DATA_W-1:0]      in_data,
  input  logic                          in_valid,
  output logic signed [DATA_W+CNT_W-1:0] sum_out,
  output logic                          sum_valid,
  input  logic                          sum_ready,
  output logic                          busy,
  output logic                          overrun,
  output logic [1:0]                    state_out,
  output logic [CNT_W-1:0]              win_cnt
);

  localparam int ACC_W = DATA_W + CNT_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_ACCUM  = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // Registered state
  logic [1:0]              state;
  logic [CNT_W-1:0]        settle_cnt;
  logic [CNT_W-1:0]        len_q;
  logic                    cont_q;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] sum_q;
  logic                    sum_valid_q;
  logic                    overrun_q;

  // Next-state values
  logic [1:0]              state_d;
  logic [CNT_W-1:0]        settle_cnt_d;
  logic [CNT_W-1:0]        len_d;
  logic                    cont_d;
  logic signed [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0]        cnt_d;
  logic signed [ACC_W-1:0] sum_d;
  logic                    sum_valid_d;
  logic                    overrun_d;

  // Datapath helpers
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_plus;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    accept;
  logic                    complete;
  logic                    handshake;

  // Sign-extended sample, running sum, and window-completion detection.
  // cnt_q is always below len_q in ACCUM, so cnt_inc cannot wrap.
  always_comb begin
    sample_ext = {{CNT_W{in_data[DATA_W-1]}}, in_data};
    acc_plus   = acc + sample_ext;
    cnt_inc    = cnt_q + CNT_W'(1);
    accept     = (state == S_ACCUM) && in_valid;
    complete   = accept && (cnt_inc == len_q);
    handshake  = sum_valid_q && sum_ready;
  end

  // Next-state and datapath update logic for the window sequencer.
  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    len_d        = len_q;
    cont_d       = cont_q;
    acc_d        = acc;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    sum_valid_d  = sum_valid_q;
    overrun_d    = overrun_q;

    // Output register: a transfer empties it, a completing window refills
    // it. A refill in the same cycle as a transfer is not an overrun.
    if (handshake) begin
      sum_valid_d = 1'b0;
    end
    if (complete) begin
      sum_d       = acc_plus;
      sum_valid_d = 1'b1;
      if (sum_valid_q && !sum_ready) begin
        overrun_d = 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        // start together with stop is treated as a cancelled request.
        if (start && !stop) begin
          len_d     = (win_len == '0) ? CNT_W'(1) : win_len;
          cont_d    = continuous;
          acc_d     = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
          if (settle_len != '0) begin
            settle_cnt_d = settle_len;
            state_d      = S_SETTLE;
          end else begin
            settle_cnt_d = '0;
            state_d      = S_ACCUM;
          end
        end
      end

      S_SETTLE: begin
        // settle_cnt holds the cycles left including the current one.
        if (stop) begin
          settle_cnt_d = '0;
          state_d      = S_IDLE;
        end else if (settle_cnt <= CNT_W'(1)) begin
          settle_cnt_d = '0;
          state_d      = S_ACCUM;
        end else begin
          settle_cnt_d = settle_cnt - CNT_W'(1);
        end
      end

      S_ACCUM: begin
        if (complete) begin
          acc_d = '0;
          cnt_d = '0;
          if (stop) begin
            state_d = S_IDLE;
          end else if (cont_q) begin
            state_d = S_ACCUM;
          end else begin
            state_d = S_HOLD;
          end
        end else if (stop) begin
          // Abort: the partial window is discarded.
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (accept) begin
          acc_d = acc_plus;
          cnt_d = cnt_inc;
        end
      end

      S_HOLD: begin
        // stop leaves the pending result in place for a later transfer.
        if (stop || handshake) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer registers with asynchronous reset to the idle, empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      settle_cnt  <= '0;
      len_q       <= '0;
      cont_q      <= 1'b0;
      acc         <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_d;
      settle_cnt  <= settle_cnt_d;
      len_q       <= len_d;
      cont_q      <= cont_d;
      acc         <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Output mapping.
  always_comb begin
    sum_out   = sum_q;
    sum_valid = sum_valid_q;
    overrun   = overrun_q;
    busy      = (state != S_IDLE);
    state_out = state;
    win_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_sum_window_ctrl.sv
// Directed bench for sum_window_ctrl: single-shot, full-length window,
// settle timing, continuous windows with overrun, abort, and async reset.
module tb_sum_window_ctrl;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  logic                            clk;
  logic                            rst;
  logic                            start;
  logic                            stop;
  logic                            continuous;
  logic [CNT_W-1:0]                win_len;
  logic [CNT_W-1:0]                settle_len;
  logic signed [DATA_W-1:0]        in_data;
  logic                            in_valid;
  logic signed [DATA_W+CNT_W-1:0]  sum_out;
  logic                            sum_valid;
  logic                            sum_ready;
  logic                            busy;
  logic                            overrun;
  logic [1:0]                      state_out;
  logic [CNT_W-1:0]                win_cnt;

  int n_cmp;
  int n_err;
  int settle_seen;

  sum_window_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .win_len    (win_len),
    .settle_len (settle_len),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .busy       (busy),
    .overrun    (overrun),
    .state_out  (state_out),
    .win_cnt    (win_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    continuous = 1'b0;
    win_len = '0;
    settle_len = '0;
    in_data = '0;
    in_valid = 1'b0;
    sum_ready = 1'b0;
    ticks(2);
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_state", 32'(state_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(sum_valid), 0);
    check("rst_sum", sum_out, 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_wincnt", 32'(win_cnt), 0);

    // 1: single-shot window of four 1000s
    win_len = 16'd4; settle_len = 16'd0; continuous = 1'b0;
    in_data = 16'sd1000; in_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_accum", 32'(state_out), 2);
    check("t1_busy", 32'(busy), 1);
    ticks(3);
    check("t1_cnt3", 32'(win_cnt), 3);
    check("t1_notyet", 32'(sum_valid), 0);
    tick();
    check("t1_valid", 32'(sum_valid), 1);
    check("t1_sum", sum_out, 4000);
    check("t1_hold", 32'(state_out), 3);
    check("t1_cnt0", 32'(win_cnt), 0);
    in_valid = 1'b0; sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("t1_idle", 32'(state_out), 0);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_taken", 32'(sum_valid), 0);

    // 2: maximum window of most-negative samples, no wrap
    win_len = 16'hFFFF; in_data = -16'sd32768; in_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    ticks(65534);
    check("t2_cnt", 32'(win_cnt), 65534);
    check("t2_notyet", 32'(sum_valid), 0);
    tick();
    check("t2_valid", 32'(sum_valid), 1);
    check("t2_sum", sum_out, -2147450880);
    check("t2_hold", 32'(state_out), 3);
    in_valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t2_stop_idle", 32'(state_out), 0);
    check("t2_stop_keep", 32'(sum_valid), 1);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("t2_taken", 32'(sum_valid), 0);

    // 3: 10 settle cycles ignore 5s, then three 7s
    settle_len = 16'd10; win_len = 16'd3; in_data = 16'sd5; in_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    settle_seen = 0;
    for (int i = 0; i < 20 && state_out == 2'd1; i++) begin
      settle_seen++;
      tick();
    end
    in_data = 16'sd7;
    check("t3_settle_len", 32'(settle_seen), 10);
    check("t3_accum", 32'(state_out), 2);
    ticks(3);
    check("t3_valid", 32'(sum_valid), 1);
    check("t3_sum", sum_out, 21);
    in_valid = 1'b0; sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("t3_idle", 32'(state_out), 0);

    // 4: continuous windows of two 3s with a stalled consumer
    settle_len = 16'd0; win_len = 16'd2; continuous = 1'b1;
    in_data = 16'sd3; in_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    ticks(2);
    check("t4_w1_valid", 32'(sum_valid), 1);
    check("t4_w1_ovr", 32'(overrun), 0);
    tick();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("t4_w2_hs_valid", 32'(sum_valid), 1);
    check("t4_w2_hs_ovr", 32'(overrun), 0);
    ticks(2);
    check("t4_w3_ovr", 32'(overrun), 1);
    ticks(2);
    check("t4_w4_ovr", 32'(overrun), 1);
    check("t4_w4_valid", 32'(sum_valid), 1);
    check("t4_w4_sum", sum_out, 6);
    check("t4_w4_accum", 32'(state_out), 2);
    in_valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_stop_idle", 32'(state_out), 0);
    check("t4_stop_keep", 32'(sum_valid), 1);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("t4_taken", 32'(sum_valid), 0);

    // 5: abort after 5 of 8 samples, then start+stop together
    continuous = 1'b0; win_len = 16'd8; in_data = 16'sd2; in_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(5);
    check("t5_cnt5", 32'(win_cnt), 5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_idle", 32'(state_out), 0);
    check("t5_cnt0", 32'(win_cnt), 0);
    check("t5_novalid", 32'(sum_valid), 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t5_ss_idle", 32'(state_out), 0);
    check("t5_ss_busy", 32'(busy), 0);
    in_valid = 1'b0;

    // 6: async reset mid-ACCUM with a result pending, then win_len=0
    continuous = 1'b1; win_len = 16'd3; in_data = 16'sd4; in_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4);
    check("t6_pending", 32'(sum_valid), 1);
    check("t6_midcnt", 32'(win_cnt), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_state", 32'(state_out), 0);
    check("t6_rst_valid", 32'(sum_valid), 0);
    check("t6_rst_sum", sum_out, 0);
    check("t6_rst_cnt", 32'(win_cnt), 0);
    check("t6_rst_busy", 32'(busy), 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    continuous = 1'b0; win_len = 16'd0; in_data = -16'sd9; in_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b0;
    check("t6_len0_valid", 32'(sum_valid), 1);
    check("t6_len0_sum", sum_out, -9);
    check("t6_len0_hold", 32'(state_out), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
